// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle for the multicycle controller.
// master: datapath side (drives instruction fields and ALU zero flag)
// slave : controller side (drives strobes, selects, debug state)
//   op, funct      instruction register fields
//   zero           ALU zero flag, current cycle
//   iord..extop    single-bit datapath strobes / selects
//   alusrcb, pcsrc 2-bit mux selects
//   pcen           PC write enable
//   alucontrol     ALU operation
//   illegal        illegal-opcode indication
//   state          FSM state, for debug
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic       extop;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  modport master (
    output op, funct, zero,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, extop,
    input  alusrcb, pcsrc, pcen, alucontrol, illegal, state
  );

  modport slave (
    input  op, funct, zero,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, extop,
    output alusrcb, pcsrc, pcen, alucontrol, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style main controller: Moore FSM with registered strobes,
// combinational PC enable and ALU control decode.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low reset
//   bus    multicycle_ctrl_if.slave (instruction fields in, strobes out)
// Parameters:
//   EXT_OPS       1 enables ORI/BNE, 0 treats them as illegal
//   TRAP_ILLEGAL  1 locks in ERROR on an illegal op, 0 skips and refetches
//
// state   | meaning
// FETCH   | 0  read instruction, PC += 4
// DECODE  | 1  register read, branch target into ALUOut
// MEMADR  | 2  load/store address
// MEMRD   | 3  load data read
// MEMWB   | 4  load writeback
// MEMWR   | 5  store write
// RTYPEEX | 6  R-type execute
// RTYPEWB | 7  R-type writeback
// BEQEX   | 8  branch if equal
// ADDIEX  | 9  addi execute
// ADDIWB  | 10 immediate writeback (addi/ori)
// JEX     | 11 jump
// ORIEX   | 12 ori execute
// BNEEX   | 13 branch if not equal
// ERROR   | 14 illegal-op trap, held until reset
module multicycle_ctrl #(
  parameter bit EXT_OPS      = 1'b1,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input logic           clk,
  input logic           reset,
  multicycle_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6, RTYPEWB = 4'd7,
    BEQEX   = 4'd8,  ADDIEX  = 4'd9,  ADDIWB = 4'd10, JEX    = 4'd11,
    ORIEX   = 4'd12, BNEEX   = 4'd13, ERROR  = 4'd14
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic       extop;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       pcwrite;
    logic       branch;
    logic       bne;
  } ctl_t;

  state_t cur, nxt;
  ctl_t   ctl;
  logic   op_legal;

  function automatic ctl_t moore_outs(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:   begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1; end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMRD:   c.iord = 1'b1;
      MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      RTYPEEX: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      RTYPEWB: begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      BEQEX:   begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1; end
      BNEEX:   begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.bne = 1'b1; end
      ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      ORIEX:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = 2'b11; c.extop = 1'b1; end
      ADDIWB:  c.regwrite = 1'b1;
      JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    op_legal = 1'b0;
    case (bus.op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      OP_ORI, OP_BNE:                            op_legal = EXT_OPS;
      default:                                   op_legal = 1'b0;
    endcase
  end

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:  nxt = DECODE;
      DECODE: begin
        if (!op_legal) nxt = TRAP_ILLEGAL ? ERROR : FETCH;
        else begin
          case (bus.op)
            OP_LW, OP_SW: nxt = MEMADR;
            OP_R:         nxt = RTYPEEX;
            OP_BEQ:       nxt = BEQEX;
            OP_ADDI:      nxt = ADDIEX;
            OP_J:         nxt = JEX;
            OP_ORI:       nxt = ORIEX;
            OP_BNE:       nxt = BNEEX;
            default:      nxt = FETCH;
          endcase
        end
      end
      MEMADR:         nxt = (bus.op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:          nxt = MEMWB;
      RTYPEEX:        nxt = RTYPEWB;
      ADDIEX, ORIEX:  nxt = ADDIWB;
      ERROR:          nxt = ERROR;
      default:        nxt = FETCH;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur <= FETCH;
      ctl <= moore_outs(FETCH);
    end else begin
      cur <= nxt;
      ctl <= moore_outs(nxt);
    end
  end

  always_comb begin
    bus.alucontrol = 3'b010;
    case (ctl.aluop)
      2'b00: bus.alucontrol = 3'b010;
      2'b01: bus.alucontrol = 3'b110;
      2'b11: bus.alucontrol = 3'b001;
      default: begin
        case (bus.funct)
          6'b100000: bus.alucontrol = 3'b010;
          6'b100010: bus.alucontrol = 3'b110;
          6'b100100: bus.alucontrol = 3'b000;
          6'b100101: bus.alucontrol = 3'b001;
          6'b101010: bus.alucontrol = 3'b111;
          default:   bus.alucontrol = 3'b000;
        endcase
      end
    endcase
  end

  assign bus.state    = cur;
  assign bus.iord     = ctl.iord;
  assign bus.regdst   = ctl.regdst;
  assign bus.memtoreg = ctl.memtoreg;
  assign bus.alusrca  = ctl.alusrca;
  assign bus.extop    = ctl.extop;
  assign bus.alusrcb  = ctl.alusrcb;
  assign bus.pcsrc    = ctl.pcsrc;
  // Write strobes are gated by reset so an aborted instruction cannot commit.
  assign bus.memwrite = ctl.memwrite & reset;
  assign bus.irwrite  = ctl.irwrite & reset;
  assign bus.regwrite = ctl.regwrite & reset;
  assign bus.pcen     = reset & (ctl.pcwrite | (ctl.branch & bus.zero) | (ctl.bne & ~bus.zero));
  // In skip mode the illegal flag is a pulse on the DECODE cycle that sees the bad op.
  assign bus.illegal  = reset & ((cur == ERROR) |
                                 ((cur == DECODE) & ~op_legal & ~TRAP_ILLEGAL));

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic clk;
  logic reset;
  logic [5:0] op_d;
  logic [5:0] funct_d;
  logic zero_d;
  logic sel;
  bit   cur_ext;
  bit   cur_trap;

  int n_chk;
  int n_pass;
  int path[$];

  multicycle_ctrl_if ifa ();
  multicycle_ctrl_if ifb ();

  assign ifa.op = op_d;
  assign ifa.funct = funct_d;
  assign ifa.zero = zero_d;
  assign ifb.op = op_d;
  assign ifb.funct = funct_d;
  assign ifb.zero = zero_d;

  multicycle_ctrl #(.EXT_OPS(1'b1), .TRAP_ILLEGAL(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  multicycle_ctrl #(.EXT_OPS(1'b0), .TRAP_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  logic [15:0] vec_a, vec_b, obs_vec;
  logic [3:0]  obs_state;
  logic        obs_illegal;

  assign vec_a = {ifa.iord, ifa.memwrite, ifa.irwrite, ifa.regdst, ifa.memtoreg, ifa.regwrite,
                  ifa.alusrca, ifa.extop, ifa.alusrcb, ifa.pcsrc, ifa.pcen, ifa.alucontrol};
  assign vec_b = {ifb.iord, ifb.memwrite, ifb.irwrite, ifb.regdst, ifb.memtoreg, ifb.regwrite,
                  ifb.alusrca, ifb.extop, ifb.alusrcb, ifb.pcsrc, ifb.pcen, ifb.alucontrol};
  assign obs_vec     = sel ? vec_b : vec_a;
  assign obs_state   = sel ? ifb.state : ifa.state;
  assign obs_illegal = sel ? ifb.illegal : ifa.illegal;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit is_legal(logic [5:0] o);
    if (o inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J}) return 1'b1;
    if (o inside {OP_ORI, OP_BNE}) return cur_ext;
    return 1'b0;
  endfunction

  function automatic logic [2:0] rtype_alu(logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

  // Expected output word per state, field order matches vec_a/vec_b.
  function automatic logic [15:0] exp_vec(int st, logic z, logic [5:0] f);
    logic iord, mw, irw, rd, m2r, rw, asa, ext, pcen;
    logic [1:0] asb, pcs;
    logic [2:0] alu;
    {iord, mw, irw, rd, m2r, rw, asa, ext, pcen} = '0;
    asb = 2'b00; pcs = 2'b00; alu = 3'b010;
    case (st)
      0:  begin asb = 2'b01; irw = 1; pcen = 1; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin asa = 1; alu = rtype_alu(f); end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; alu = 3'b110; pcs = 2'b01; pcen = z; end
      13: begin asa = 1; alu = 3'b110; pcs = 2'b01; pcen = ~z; end
      9:  begin asa = 1; asb = 2'b10; end
      12: begin asa = 1; asb = 2'b10; alu = 3'b001; ext = 1; end
      10: rw = 1;
      11: begin pcs = 2'b10; pcen = 1; end
      default: ;
    endcase
    return {iord, mw, irw, rd, m2r, rw, asa, ext, asb, pcs, pcen, alu};
  endfunction

  // Sequence of states an instruction visits, derived from its latency class.
  function automatic void build_path(logic [5:0] o);
    path = {};
    path.push_back(0);
    path.push_back(1);
    if (!is_legal(o)) begin
      if (cur_trap) for (int i = 0; i < 10; i++) path.push_back(14);
      return;
    end
    case (o)
      OP_LW:   begin path.push_back(2); path.push_back(3); path.push_back(4); end
      OP_SW:   begin path.push_back(2); path.push_back(5); end
      OP_R:    begin path.push_back(6); path.push_back(7); end
      OP_ADDI: begin path.push_back(9); path.push_back(10); end
      OP_ORI:  begin path.push_back(12); path.push_back(10); end
      OP_BEQ:  path.push_back(8);
      OP_BNE:  path.push_back(13);
      default: path.push_back(11);
    endcase
  endfunction

  // Entered and left at 1 time unit after a rising edge.
  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_state", obs_state, 0);
    chk("rst_strobes", {obs_vec[14], obs_vec[13], obs_vec[10], obs_vec[3]}, 0);
    chk("rst_illegal", obs_illegal, 0);
    reset = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zsel);
    bit exp_ill;
    op_d = o;
    funct_d = f;
    build_path(o);
    foreach (path[i]) begin
      zero_d = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
      #1;
      chk("state", obs_state, path[i]);
      chk("outs", obs_vec, exp_vec(path[i], zero_d, f));
      exp_ill = (path[i] == 14) || (path[i] == 1 && !is_legal(o) && !cur_trap);
      chk("illegal", obs_illegal, exp_ill);
      @(posedge clk); #1;
    end
    if (!is_legal(o) && cur_trap) begin
      chk("trap_hold", obs_state, 14);
      reset = 1'b0;
      #1;
      chk("trap_rst_illegal", obs_illegal, 0);
      chk("trap_rst_pcen", obs_vec[3], 0);
      @(posedge clk); #1;
      chk("trap_rst_state", obs_state, 0);
      reset = 1'b1;
    end
  endtask

  task automatic run_random(input int n);
    logic [5:0] ops[8];
    logic [5:0] fns[5];
    logic [5:0] f;
    ops = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J, OP_ORI, OP_BNE};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 5) == 0) f = 6'($urandom);
      else f = fns[$urandom_range(0, 4)];
      run_instr(ops[$urandom_range(0, 7)], f, -1);
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    reset = 1'b0; op_d = OP_R; funct_d = '0; zero_d = 1'b0;
    sel = 1'b0; cur_ext = 1'b1; cur_trap = 1'b1;

    do_reset();
    run_instr(OP_LW, 6'b100000, -1);
    run_instr(OP_BEQ, 6'b0, 1);
    run_instr(OP_BEQ, 6'b0, 0);
    run_instr(OP_BNE, 6'b0, 1);
    run_instr(OP_BNE, 6'b0, 0);
    run_instr(OP_R, 6'b101010, -1);
    run_instr(OP_R, 6'b111111, -1);
    run_instr(OP_ORI, 6'b0, -1);
    run_instr(OP_J, 6'b0, -1);
    run_random(40);

    // Abort a store in its MEMWR cycle.
    op_d = OP_SW;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_in_memwr", obs_state, 5);
    reset = 1'b0;
    #1;
    chk("abort_memwrite", obs_vec[14], 0);
    chk("abort_strobes", {obs_vec[13], obs_vec[10], obs_vec[3]}, 0);
    @(posedge clk); #1;
    chk("abort_state", obs_state, 0);
    reset = 1'b1;
    run_instr(OP_ADDI, 6'b0, -1);

    run_instr(OP_BAD, 6'b0, -1);
    run_instr(OP_SW, 6'b0, -1);

    sel = 1'b1; cur_ext = 1'b0; cur_trap = 1'b0;
    do_reset();
    run_instr(OP_ORI, 6'b0, -1);
    run_instr(OP_BAD, 6'b0, -1);
    run_instr(OP_BNE, 6'b0, -1);
    run_random(25);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
